// File: rtl/miyajiro_uart_pkg.sv
// Shared types and constants for the MIYAJIRO UART transmitter and receiver.
package miyajiro_uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_t;

   localparam int UART_DATA_W              = 8;
   localparam int UART_DEFAULT_CLK_PER_BIT = 868;

endpackage

// File: rtl/miyajiro_sync_fifo.sv
// Synchronous FIFO with occupancy count; push while full and pop while empty are ignored.
module miyajiro_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_r;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_r == (AW+1)'(DEPTH));
   assign empty    = (count_r == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];
   assign count    = count_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_r <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop_ok)
            count_r <= count_r + (AW+1)'(1);
         else if (pop_ok && !push_ok)
            count_r <= count_r - (AW+1)'(1);
      end
   end

   // Storage carries no reset; contents are only observed through valid pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/miyajiro_uart_tx.sv
// Buffered 8N1 UART transmitter for the MIYAJIRO CPU output path.
// Define MIYAJIRO_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module miyajiro_uart_tx
   import miyajiro_uart_pkg::*;
#(
   parameter int CLK_PER_BIT = UART_DEFAULT_CLK_PER_BIT,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_valid,
   input  logic [UART_DATA_W-1:0]        wr_data,
   output logic                          wr_ready,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [2:0]                    state
);

   localparam int                CNT_W      = $clog2(CLK_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(CLK_PER_BIT - 1);

   uart_tx_state_t         state_r;
   logic [CNT_W-1:0]       bit_cnt;
   logic [2:0]             bit_idx;
   logic [UART_DATA_W-1:0] shifter;
   logic                   txd_r;
   logic                   busy_r;
   logic                   bit_end;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   empty;
   logic [UART_DATA_W-1:0] fifo_data;
`ifdef MIYAJIRO_UART_TX_PARITY_EN
   logic                   parity_r;
`endif

   // Write port: a byte transfers on any rising edge with wr_valid && wr_ready;
   // wr_ready is !full only, so a pop in the same cycle never frees a slot early.
   assign wr_ready = !full;
   assign push     = wr_valid && !full;
   assign bit_end  = (bit_cnt == '0);
   assign pop      = !empty && ((state_r == IDLE) || (state_r == STOP && bit_end));
   assign txd      = txd_r;
   assign busy     = busy_r;
   assign state    = state_r;

   miyajiro_sync_fifo #(
      .WIDTH (UART_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (wr_data),
      .pop       (pop),
      .pop_data  (fifo_data),
      .count     (fifo_count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         txd_r    <= 1'b1;
         busy_r   <= 1'b0;
         bit_cnt  <= CNT_RELOAD;
         bit_idx  <= '0;
         shifter  <= '0;
`ifdef MIYAJIRO_UART_TX_PARITY_EN
         parity_r <= 1'b0;
`endif
      end else if (pop) begin
         // Popping from IDLE or the last STOP cycle both start a frame next cycle.
         state_r  <= START;
         txd_r    <= 1'b0;
         busy_r   <= 1'b1;
         bit_cnt  <= CNT_RELOAD;
         shifter  <= fifo_data;
`ifdef MIYAJIRO_UART_TX_PARITY_EN
         parity_r <= ^fifo_data;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               txd_r  <= 1'b1;
               busy_r <= push;
            end
            START: begin
               if (bit_end) begin
                  state_r <= DATA;
                  txd_r   <= shifter[0];
                  shifter <= shifter >> 1;
                  bit_idx <= '0;
                  bit_cnt <= CNT_RELOAD;
               end else begin
                  bit_cnt <= bit_cnt - CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  bit_cnt <= CNT_RELOAD;
                  if (bit_idx == 3'd7) begin
`ifdef MIYAJIRO_UART_TX_PARITY_EN
                     state_r <= PARITY;
                     txd_r   <= parity_r;
`else
                     state_r <= STOP;
                     txd_r   <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd_r   <= shifter[0];
                     shifter <= shifter >> 1;
                  end
               end else begin
                  bit_cnt <= bit_cnt - CNT_W'(1);
               end
            end
`ifdef MIYAJIRO_UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state_r <= STOP;
                  txd_r   <= 1'b1;
                  bit_cnt <= CNT_RELOAD;
               end else begin
                  bit_cnt <= bit_cnt - CNT_W'(1);
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  state_r <= IDLE;
                  txd_r   <= 1'b1;
                  busy_r  <= push;
                  bit_cnt <= CNT_RELOAD;
               end else begin
                  bit_cnt <= bit_cnt - CNT_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               txd_r   <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_miyajiro_uart_tx.sv
// Testbench for miyajiro_uart_tx; a line receiver decodes txd against a queue of expected bytes.
module tb_miyajiro_uart_tx;
   import miyajiro_uart_pkg::*;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef MIYAJIRO_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = CPB * NBITS;

   logic       clk;
   logic       reset;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       txd;
   logic       busy;
   logic [2:0] fifo_count;
   logic [2:0] dbg_state;

   int         n_checks;
   int         n_fail;
   int         cyc;
   bit         rx_en;
   logic [7:0] exp_q[$];
   int         start_q[$];
   logic       par_q[$];
   logic [7:0] mon_byte;
   logic       mon_par;
   logic [7:0] mon_exp;

   miyajiro_uart_tx #(
      .CLK_PER_BIT (CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .txd        (txd),
      .busy       (busy),
      .fifo_count (fifo_count),
      .state      (dbg_state)
   );

   // Clock, cycle counter and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Expected line level o cycles after the start bit begins
   function automatic logic frame_bit(input logic [7:0] d, input int o);
      int b;
      if (o < 0 || o >= FRAME) return 1'b1;
      b = o / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
`ifdef MIYAJIRO_UART_TX_PARITY_EN
      if (b == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   // Line receiver: samples the first cycle of each bit and scores against exp_q
   initial begin
      forever begin
         @(negedge clk);
         if (rx_en && txd === 1'b0) begin
            start_q.push_back(cyc);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               mon_byte[i] = txd;
            end
`ifdef MIYAJIRO_UART_TX_PARITY_EN
            repeat (CPB) @(negedge clk);
            mon_par = txd;
            par_q.push_back(mon_par);
`endif
            repeat (CPB) @(negedge clk);
            n_checks++;
            if (txd !== 1'b1) begin
               n_fail++;
               $display("FAIL rx_stop: got %b required 1", txd);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rx_unexpected: got frame 0x%02h required none", mon_byte);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_byte !== mon_exp) begin
                  n_fail++;
                  $display("FAIL rx_data: got 0x%02h required 0x%02h", mon_byte, mon_exp);
               end
`ifdef MIYAJIRO_UART_TX_PARITY_EN
               n_checks++;
               if (mon_par !== ^mon_exp) begin
                  n_fail++;
                  $display("FAIL rx_parity: got %b required %b", mon_par, ^mon_exp);
               end
`endif
            end
            repeat (CPB - 1) @(negedge clk);
         end
      end
   end

   // Driver: entered and left at posedge+#1; holds wr_valid until wr_ready
   task automatic send(input logic [7:0] d, input bit track);
      int  waited;
      bit  ok;
      waited   = 0;
      ok       = 1'b0;
      wr_valid = 1'b1;
      wr_data  = d;
      while (!ok && waited < 2000) begin
         @(negedge clk);
         ok = wr_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      wr_valid = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: wr_ready stayed 0, required 1 within 2000 cycles");
      end else if (track) begin
         exp_q.push_back(d);
      end
   endtask

   task automatic wait_idle();
      int  waited;
      bit  done;
      waited = 0;
      done   = 1'b0;
      while (!done && waited < 3000) begin
         @(negedge clk);
         done = (busy === 1'b0) && (exp_q.size() == 0);
         waited++;
      end
      @(posedge clk);
      #1;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_timeout: busy=%b pending=%0d, required 0 and 0", busy, exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      wr_valid = 1'b0;
      wr_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         n_checks++;
         if (txd !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idle: txd=%b busy=%b wr_ready=%b count=%0d required 1 0 1 0",
                     txd, busy, wr_ready, fifo_count);
         end
      end
      n_checks++;
      if (dbg_state !== 3'(IDLE)) begin
         n_fail++;
         $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      int         c;
      logic [7:0] d;
      logic       exp_txd;
      logic       exp_busy;
      logic [2:0] exp_cnt;
      d        = 8'hA5;
      c        = cyc;
      wr_valid = 1'b1;
      wr_data  = d;
      exp_q.push_back(d);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      for (int k = c + 1; k <= c + 2 + FRAME; k++) begin
         @(negedge clk);
         exp_txd  = frame_bit(d, k - (c + 2));
         exp_busy = (k < c + 2 + FRAME);
         exp_cnt  = (k == c + 1) ? 3'd1 : 3'd0;
         n_checks++;
         if (txd !== exp_txd || busy !== exp_busy || fifo_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL single_a5 @+%0d: txd=%b busy=%b count=%0d required %b %b %0d",
                     k - c, txd, busy, fifo_count, exp_txd, exp_busy, exp_cnt);
         end
         @(posedge clk);
         #1;
      end
      wait_idle();
   endtask

   task automatic test_full_drop();
      start_q.delete();
      for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b1);
      wr_valid = 1'b1;
      wr_data  = 8'hEE;
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b0 || fifo_count !== 3'd4) begin
         n_fail++;
         $display("FAIL full_flags: wr_ready=%b count=%0d required 0 4", wr_ready, fifo_count);
      end
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (fifo_count !== 3'd4) begin
         n_fail++;
         $display("FAIL full_drop_count: got %0d required 4", fifo_count);
      end
      @(posedge clk);
      #1;
      wait_idle();
      n_checks++;
      if (start_q.size() != 5) begin
         n_fail++;
         $display("FAIL full_frames: got %0d frames required 5", start_q.size());
      end
   endtask

   task automatic test_back_to_back();
      start_q.delete();
      for (int i = 0; i < 5; i++) send(8'(i), 1'b1);
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b0 || fifo_count !== 3'd4) begin
         n_fail++;
         $display("FAIL b2b_full: wr_ready=%b count=%0d required 0 4", wr_ready, fifo_count);
      end
      @(posedge clk);
      #1;
      send(8'h05, 1'b1);
      wait_idle();
      n_checks++;
      if (start_q.size() != 6) begin
         n_fail++;
         $display("FAIL b2b_frames: got %0d frames required 6", start_q.size());
      end else begin
         for (int i = 1; i < 6; i++) begin
            n_checks++;
            if (start_q[i] - start_q[i-1] != FRAME) begin
               n_fail++;
               $display("FAIL b2b_gap %0d: got %0d cycles required %0d",
                        i, start_q[i] - start_q[i-1], FRAME);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      rx_en = 1'b0;
      send(8'hFF, 1'b0);
      send(8'h12, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++;
      if (fifo_count !== 3'd1 || dbg_state !== 3'(DATA)) begin
         n_fail++;
         $display("FAIL mid_pre: count=%0d state=%0d required 1 %0d", fifo_count, dbg_state, DATA);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (txd !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset: txd=%b count=%0d busy=%b wr_ready=%b required 1 0 0 1",
                  txd, fifo_count, busy, wr_ready);
      end
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         n_checks++;
         if (txd !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_quiet: txd=%b busy=%b required 1 0", txd, busy);
         end
      end
      @(posedge clk);
      #1;
      rx_en = 1'b1;
   endtask

`ifdef MIYAJIRO_UART_TX_PARITY_EN
   task automatic test_parity();
      start_q.delete();
      par_q.delete();
      send(8'h07, 1'b1);
      send(8'h03, 1'b1);
      wait_idle();
      n_checks++;
      if (par_q.size() != 2) begin
         n_fail++;
         $display("FAIL parity_count: got %0d required 2", par_q.size());
      end else begin
         n_checks++;
         if (par_q[0] !== 1'b1 || par_q[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_bits: got %b %b required 1 0", par_q[0], par_q[1]);
         end
      end
      n_checks++;
      if (start_q.size() != 2 || start_q[1] - start_q[0] != 44) begin
         n_fail++;
         $display("FAIL parity_frame_len: frames=%0d required 2 with 44-cycle spacing", start_q.size());
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rx_en    = 1'b1;
      test_reset();
      test_single();
      test_full_drop();
      test_back_to_back();
      test_reset_mid();
`ifdef MIYAJIRO_UART_TX_PARITY_EN
      test_parity();
`endif
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover: %0d bytes never received, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
